// File: rtl/pipe_pkg.sv
// Shared definitions for the five-stage pipeline.
// Holds the decoded control-word width, the bit position of every control
// field inside that word, and the register-zero specifier.
// No ports: this is a package imported by the pipeline stages.
package pipe_pkg;

    // Decoded control word: {reg_write, mem_read, mem_write, mem_to_reg,
    //                        alu_src, reg_dst, alu_op[3:0]}
    localparam int CTRL_W     = 10;

    localparam int REG_WRITE  = 9;
    localparam int MEM_READ   = 8;
    localparam int MEM_WRITE  = 7;
    localparam int MEM_TO_REG = 6;
    localparam int ALU_SRC    = 5;
    localparam int REG_DST    = 4;
    localparam int ALU_OP_MSB = 3;
    localparam int ALU_OP_LSB = 0;

    // Register 0 always reads as zero and is never written.
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare.
// Purely combinational: flags when the instruction in decode reads the
// register that a load currently in EX will write. Kept as a separate block
// so the branch-in-ID hazard path can reuse the same compare.
// Ports:
//   ex_valid_i, ex_mem_read_i, ex_rt_i   : state of the instruction in EX
//   id_valid_i, id_uses_rs_i/rt_i,
//   id_rs_i, id_rt_i                     : instruction in decode
//   load_use_o                           : hazard present
module load_use_detect
    import pipe_pkg::*;
(
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rt_i,
    input  logic       id_valid_i,
    input  logic       id_uses_rs_i,
    input  logic       id_uses_rt_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    output logic       load_use_o
);

    logic rs_hit;
    logic rt_hit;

    // Only count a match on a source the decoded instruction really reads;
    // unused specifier fields often hold immediate bits.
    assign rs_hit = id_uses_rs_i && (id_rs_i == ex_rt_i);
    assign rt_hit = id_uses_rt_i && (id_rt_i == ex_rt_i);

    // A load to register 0 writes nothing, so nothing can depend on it.
    assign load_use_o = ex_valid_i && ex_mem_read_i && (ex_rt_i != REG_ZERO) &&
                        id_valid_i && (rs_hit || rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register.
// Captures operands, immediate, specifiers and decoded control from decode
// every rising edge and presents them to EX one cycle later. Detects
// load-use hazards: raises stall (for PC and IF/ID) and inserts a bubble
// into EX. A taken branch/jump flush also inserts a bubble and has priority
// over the stall. bubble_cnt counts every inserted bubble, wrapping.
// Ports:
//   clk, rst_n                   : clock, synchronous active-low reset
//   id_*                         : decode-stage inputs
//   flush                        : kill the decode slot
//   stall                        : combinational hold request to IF/ID
//   ex_*                         : registered EX-stage outputs
//   bubble_cnt                   : number of bubbles inserted
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [31:0]       id_rd1,
    input  logic [31:0]       id_rd2,
    input  logic [31:0]       id_imm,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_rd1,
    output logic [31:0]       ex_rd2,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_dst,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              valid_q, valid_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       rd1_q, rd1_d;
    logic [31:0]       rd2_q, rd2_d;
    logic [31:0]       imm_q, imm_d;
    logic [4:0]        rs_q, rs_d;
    logic [4:0]        rt_q, rt_d;
    logic [4:0]        dst_q, dst_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              load_use;

    load_use_detect u_load_use_detect (
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (ctrl_q[MEM_READ]),
        .ex_rt_i       (rt_q),
        .id_valid_i    (id_valid),
        .id_uses_rs_i  (id_uses_rs),
        .id_uses_rt_i  (id_uses_rt),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .load_use_o    (load_use)
    );

    // The flushed instruction dies anyway, so there is nothing to hold.
    assign stall = load_use && !flush;

    always_comb begin
        valid_d = 1'b0;
        pc_d    = '0;
        rd1_d   = '0;
        rd2_d   = '0;
        imm_d   = '0;
        rs_d    = '0;
        rt_d    = '0;
        dst_d   = '0;
        ctrl_d  = '0;
        cnt_d   = cnt_q;

        if (flush || load_use) begin
            // Bubble: everything stays cleared, one count per bubble even
            // when both causes coincide.
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            valid_d = id_valid;
            pc_d    = id_pc;
            rd1_d   = id_rd1;
            rd2_d   = id_rd2;
            imm_d   = id_imm;
            rs_d    = id_rs;
            rt_d    = id_rt;
            dst_d   = id_ctrl[REG_DST] ? id_rd : id_rt;
            ctrl_d  = id_valid ? id_ctrl : '0;
            // Dropping reg_write here is what keeps register 0 constant.
            if (dst_d == REG_ZERO) begin
                ctrl_d[REG_WRITE] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            dst_q   <= '0;
            ctrl_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            dst_q   <= dst_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_pc      = pc_q;
    assign ex_rd1     = rd1_q;
    assign ex_rd2     = rd2_q;
    assign ex_imm     = imm_q;
    assign ex_rs      = rs_q;
    assign ex_rt      = rt_q;
    assign ex_dst     = dst_q;
    assign ex_ctrl    = ctrl_q;
    assign bubble_cnt = cnt_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the 32-bit five-stage pipeline. It sits directly downstream of the register file and decode logic. It captures the two read operands, the sign-extended immediate, the register specifiers and the decoded control word on each rising edge, and presents them to the EX stage. It also detects load-use hazards: it stalls IF/ID and inserts a bubble into EX. A branch-taken flush also inserts a bubble. A counter tracks inserted bubbles.

## Interface
Parameters:
- `CTRL_W`, default 10: width of the decoded control word. Field positions come from the shared package.
- `CNT_W`, default 16: width of the bubble counter.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  reset. One clock; reset is synchronous and active-low.
- `id_valid`  in  1  decode slot holds a real instruction.
- `id_pc`  in  32  PC+4 of the decoded instruction.
- `id_rd1`, `id_rd2`  in  32  register-file read data for rs and rt.
- `id_imm`  in  32  sign-extended immediate.
- `id_rs`, `id_rt`, `id_rd`  in  5  register specifiers.
- `id_uses_rs`, `id_uses_rt`  in  1  instruction actually reads rs / rt.
- `id_ctrl`  in  CTRL_W  decoded control: reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op[3:0].
- `flush`  in  1  branch/jump taken in EX; kill the decode slot.
- `stall`  out  1  combinational; freezes PC and IF/ID.
- `ex_valid`  out  1  EX slot valid.
- `ex_pc`, `ex_rd1`, `ex_rd2`, `ex_imm`  out  32  registered copies.
- `ex_rs`, `ex_rt`  out  5  registered specifiers, for the forwarding unit.
- `ex_dst`  out  5  resolved destination register.
- `ex_ctrl`  out  CTRL_W  registered control word.
- `bubble_cnt`  out  CNT_W  count of inserted bubbles.

## Operation
- Load-use condition: `load_use = ex_valid & ex_ctrl.mem_read & (ex_rt != 0) & id_valid & ((id_uses_rs & id_rs == ex_rt) | (id_uses_rt & id_rt == ex_rt))`.
- `stall = load_use & ~flush`. A flush has priority because the stalled instruction dies anyway.
- Per rising edge, in priority order:
  - `!rst_n`: every output register is cleared to 0, including `ex_valid`, `ex_ctrl`, `ex_dst` and `bubble_cnt`.
  - `flush`: bubble. `ex_valid`=0 and `ex_ctrl`=0; data and specifier fields are cleared to 0. `bubble_cnt` increments.
  - `load_use`: bubble, identical to the flush case. `bubble_cnt` increments.
  - Otherwise: capture all `id_*` fields. `ex_valid` takes `id_valid`. `ex_ctrl` takes `id_ctrl` if `id_valid`, else 0.
- Destination resolution at capture: `ex_dst = reg_dst ? id_rd : id_rt`.
- Writes to register 0: if the resolved `ex_dst` is 0, reg_write is cleared in `ex_ctrl`. This is what keeps register 0 constant.
- `bubble_cnt` wraps modulo 2^CNT_W. An invalid `id_valid`=0 slot passing through is not counted.
- Only ID/EX state is updated here. Holding PC and IF/ID on `stall` is the responsibility of those stages.

## Timing
- Latency: 1 cycle from ID inputs to `ex_*` outputs.
- `stall` is valid in the same cycle as the offending ID inputs. It depends only on current `ex_*` registers and `id_*` inputs.
- Stall duration is exactly one cycle per load-use pair: after the bubble, `ex_valid`=0, so `load_use` deasserts. The held instruction is then captured, and the load's data is forwarded from MEM/WB.
- The register file writes on the falling edge, so `id_rd1`/`id_rd2` already reflect the WB write of the same cycle. No WB-to-ID bypass exists in this block.
- Reset asserted mid-stall: outputs clear on that edge and `stall` drops, because `ex_valid`=0.
- `flush` and `load_use` in the same cycle produce one bubble and one count increment.

## Structure
- Shared package `pipe_pkg`:
  - `CTRL_W`
  - control-bit index constants (REG_WRITE, MEM_READ, MEM_WRITE, MEM_TO_REG, ALU_SRC, REG_DST, ALU_OP_LSB/MSB)
  - register-zero constant
- Sub-module `load_use_detect`: purely combinational compare logic, reused later by the branch-in-ID hazard path.
- Everything else is flat registers in `id_ex_stage`.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with random ID inputs → all `ex_*`=0, `stall`=0, `bubble_cnt`=0.
- Pass-through: `add` with rs=1, rt=2, rd=3, rd1=1, rd2=2, reg_dst=1 → next cycle `ex_rd1`=1, `ex_rd2`=2, `ex_dst`=3, `ex_valid`=1, reg_write=1.
- Load-use: `lw` writing rt=9 in EX, then `add` rs=9 in ID → `stall`=1 for exactly one cycle, a bubble enters EX, `bubble_cnt`=1, and `add` is captured on the following edge.
- No false hazard:
  - `lw` to rt=0, then a reader of register 0 → `stall`=0.
  - `lw` to rt=9, then an instruction with `id_uses_rs`=0 and rs=9 → `stall`=0.
- Flush priority: load-use condition plus `flush`=1 in the same cycle → `stall`=0, one bubble, `bubble_cnt` +1.
- Register-0 suppression and wrap:
  - `add` with rd=0 → `ex_ctrl` reg_write=0.
  - With CNT_W=4, 17 flushes → `bubble_cnt`=1.
